msg_display_scheduler: RTL and testbench
========================================

Name: msg_display_scheduler

Overview:
- Sequences message codes into the 4-digit 7-segment decoder (4-bit code input X; codes 0..14 = OFF, DIF1-3, VEL1-2, PC, PVP, Erro, Suss, Digi, Resp, 0000, blank, Cont).
- Shows a persistent background code from the menu/game FSM.
- Overlays timed one-shot messages (e.g. Erro, Suss) for a fixed hold time, optionally blinking, with a one-deep pending slot and valid/ready handshake.
- Output drives the decoder's X input directly.

Parameters:
- TICK_DIV, 25000000, clk cycles per display tick (0.5 s at 50 MHz); must be >= 2
- HOLD_TICKS, 4, ticks a one-shot message stays on display; must be >= 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bg_code  in  4  background code shown when idle
- msg_code  in  4  one-shot message code
- msg_blink  in  1  message blinks when set; sampled with msg_code
- msg_req  in  1  request valid; held until accepted
- msg_ready  out  1  slot available; transfer = msg_req & msg_ready
- flush  in  1  abort current and pending messages
- disp_code  out  4  code to decoder X, registered
- busy  out  1  high while a one-shot message is displayed
- msg_done  out  1  one-cycle pulse when a message completes its hold

Behaviour:
- Reset values:
  - disp_code = 13 (blank), busy = 0, msg_done = 0.
  - State IDLE, pending slot empty, prescaler and hold counters 0.
- Code sanitising: any code of 15 (bg or msg) is displayed as 13; disp_code is never 15.
- msg_ready = ~pend_valid & ~flush (combinational from registers plus flush).
- Prescaler: counts 0..TICK_DIV-1; tick pulses on the wrap cycle; cleared to 0 whenever a message becomes current.
- IDLE:
  - disp_code <= bg_code every cycle (1-cycle latency).
  - On transfer in cycle t: message becomes current, state SHOW, disp_code = msg_code from t+1, busy = 1 from t+1.
  - Pending slot stays empty.
- SHOW:
  - Hold counter increments on each tick; the message occupies exactly HOLD_TICKS*TICK_DIV cycles.
  - Transfer during SHOW stores code and blink in the pending slot; msg_ready then drops.
  - Blink: phase starts ON at entry and toggles on every tick. OFF phase outputs 13; ON phase outputs the message code.
- Hold expiry (last cycle of hold), msg_done pulses that cycle:
  - Pending valid: pending loads as current with no gap cycle; slot freed; prescaler, hold counter and blink phase restart.
  - Pending empty with concurrent transfer: incoming message becomes current directly (bypass).
  - Otherwise: go to IDLE; disp_code = bg_code next cycle; busy = 0.
- Flush (any state):
  - Next cycle: IDLE, pending empty, disp_code = bg_code, busy = 0.
  - No msg_done; concurrent request not accepted.
- Background changes during SHOW are ignored until IDLE.
- Async reset mid-message: immediate return to reset values; the message is lost.

Decomposition:
- Package genius_msg_pkg:
  - code constants MSG_OFF=0, MSG_DIF1..3=1..3, MSG_VEL1..2=4..5, MSG_PC=6, MSG_PVP=7, MSG_ERRO=8, MSG_SUSS=9, MSG_DIGI=10, MSG_RESP=11, MSG_ZERO=12, MSG_BLANK=13, MSG_CONT=14
  - state encoding IDLE/SHOW
- Sub-module tick_prescaler (parameter TICK_DIV; inputs clk, rst, clr; output tick).

Test Plan (TICK_DIV=4, HOLD_TICKS=3, so 12-cycle hold):
- Reset then bg_code=6 -> disp_code=13 during reset, 6 one cycle after release; msg_ready=1; busy=0.
- bg_code=6, msg_req with msg_code=8 at cycle t -> disp_code=8 for cycles t+1..t+12, msg_done pulse at t+12, disp_code=6 at t+13.
- Message 9 in SHOW, second request code 11 mid-hold -> msg_ready low after acceptance; 11 shown immediately after 9's 12 cycles with no gap; two msg_done pulses.
- msg_code=10, msg_blink=1 -> disp_code sequence 10x4, 13x4, 10x4, then bg.
- flush during SHOW with pending valid and msg_req high -> IDLE next cycle, bg shown, no msg_done, request not accepted that cycle, accepted the cycle after.
- bg_code=15 or msg_code=15 -> disp_code=13; async rst asserted mid-hold -> disp_code=13, busy=0 immediately.

Source files
------------

// File: rtl/msg_display_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// genius_msg_pkg: display code map, scheduler state encoding, code sanitiser.
// Rev 1.0
// ---------------------------------------------------------------------------
package genius_msg_pkg;

  localparam logic [3:0] MSG_OFF   = 4'd0;
  localparam logic [3:0] MSG_DIF1  = 4'd1;
  localparam logic [3:0] MSG_DIF2  = 4'd2;
  localparam logic [3:0] MSG_DIF3  = 4'd3;
  localparam logic [3:0] MSG_VEL1  = 4'd4;
  localparam logic [3:0] MSG_VEL2  = 4'd5;
  localparam logic [3:0] MSG_PC    = 4'd6;
  localparam logic [3:0] MSG_PVP   = 4'd7;
  localparam logic [3:0] MSG_ERRO  = 4'd8;
  localparam logic [3:0] MSG_SUSS  = 4'd9;
  localparam logic [3:0] MSG_DIGI  = 4'd10;
  localparam logic [3:0] MSG_RESP  = 4'd11;
  localparam logic [3:0] MSG_ZERO  = 4'd12;
  localparam logic [3:0] MSG_BLANK = 4'd13;
  localparam logic [3:0] MSG_CONT  = 4'd14;
  localparam logic [3:0] MSG_RSVD  = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // The decoder has no glyph for 15, so it is shown as blank.
  function automatic logic [3:0] sanitize_code(input logic [3:0] code);
    return (code == MSG_RSVD) ? MSG_BLANK : code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_display_scheduler_tick_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_prescaler: free-running 0..TICK_DIV-1 counter, tick on the wrap cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_display_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msg_display_scheduler: background code with timed, optionally blinking,
// one-shot message overlay and a one-deep pending slot. Rev 1.0
// ---------------------------------------------------------------------------
module msg_display_scheduler
  import genius_msg_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bg_code,
  input  logic [3:0] msg_code,
  input  logic       msg_blink,
  input  logic       msg_req,
  output logic       msg_ready,
  input  logic       flush,
  output logic [3:0] disp_code,
  output logic       busy,
  output logic       msg_done
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_e        state_q, state_d;
  logic [3:0]    cur_code_q, cur_code_d;
  logic          cur_blink_q, cur_blink_d;
  logic          phase_q, phase_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    pend_code_q, pend_code_d;
  logic          pend_blink_q, pend_blink_d;
  logic [3:0]    disp_q, disp_d;
  logic          busy_q;
  logic          load, done, tick, xfer;

  assign msg_ready = ~pend_valid_q & ~flush;
  assign xfer      = msg_req & msg_ready;
  assign msg_done  = done;
  assign disp_code = disp_q;
  assign busy      = busy_q;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .tick(tick)
  );

  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    cur_blink_d  = cur_blink_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_blink_d = pend_blink_q;
    load         = 1'b0;
    done         = 1'b0;

    if (flush) begin
      state_d      = ST_IDLE;
      pend_valid_d = 1'b0;
      hold_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            cur_code_d  = sanitize_code(msg_code);
            cur_blink_d = msg_blink;
            load        = 1'b1;
          end
        end
        ST_SHOW: begin
          if (tick && (hold_q == HOLD_LAST)) begin
            done   = 1'b1;
            hold_d = '0;
            // Back-to-back: pending first, otherwise a same-cycle request.
            if (pend_valid_q) begin
              cur_code_d   = pend_code_q;
              cur_blink_d  = pend_blink_q;
              pend_valid_d = 1'b0;
              load         = 1'b1;
            end else if (xfer) begin
              cur_code_d  = sanitize_code(msg_code);
              cur_blink_d = msg_blink;
              load        = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (tick) begin
              hold_d  = hold_q + 1'b1;
              phase_d = ~phase_q;
            end
            if (xfer) begin
              pend_valid_d = 1'b1;
              pend_code_d  = sanitize_code(msg_code);
              pend_blink_d = msg_blink;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      state_d = ST_SHOW;
      hold_d  = '0;
      phase_d = 1'b1;
    end

    if (state_d == ST_SHOW) begin
      disp_d = (cur_blink_d && !phase_d) ? MSG_BLANK : cur_code_d;
    end else begin
      disp_d = sanitize_code(bg_code);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_code_q   <= MSG_BLANK;
      cur_blink_q  <= 1'b0;
      phase_q      <= 1'b1;
      hold_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= MSG_BLANK;
      pend_blink_q <= 1'b0;
      disp_q       <= MSG_BLANK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      cur_blink_q  <= cur_blink_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_blink_q <= pend_blink_d;
      disp_q       <= disp_d;
      busy_q       <= (state_d == ST_SHOW);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_display_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_msg_display_scheduler: cycle-by-cycle vectors with TICK_DIV=4,
// HOLD_TICKS=3 (12-cycle hold), plus flush and async-reset sequences. Rev 1.0
// ---------------------------------------------------------------------------
module tb_msg_display_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bg_code, msg_code;
  logic       msg_blink, msg_req, flush;
  logic       msg_ready, busy, msg_done;
  logic [3:0] disp_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] bg;
    logic [3:0] code;
    logic       blink;
    logic       req;
    logic [3:0] e_disp;
    logic       e_busy;
    logic       e_ready;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  msg_display_scheduler #(
    .TICK_DIV  (4),
    .HOLD_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bg_code  (bg_code),
    .msg_code (msg_code),
    .msg_blink(msg_blink),
    .msg_req  (msg_req),
    .msg_ready(msg_ready),
    .flush    (flush),
    .disp_code(disp_code),
    .busy     (busy),
    .msg_done (msg_done)
  );

  function automatic void add(input int n, input logic [3:0] bg, input logic [3:0] code,
                              input logic blink, input logic req, input logic [3:0] ed,
                              input logic eb, input logic er, input logic edn);
    for (int k = 0; k < n; k++) vecs.push_back('{bg, code, blink, req, ed, eb, er, edn});
  endfunction

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, observe before the next rising edge.
  task automatic step(input int cyc, input logic [3:0] bg, input logic [3:0] code,
                      input logic blink, input logic req, input logic fl,
                      input logic [3:0] ed, input logic eb, input logic er, input logic edn);
    @(negedge clk);
    bg_code = bg; msg_code = code; msg_blink = blink; msg_req = req; flush = fl;
    #2;
    chk("disp_code", cyc, int'(disp_code), int'(ed));
    chk("busy",      cyc, int'(busy),      int'(eb));
    chk("msg_ready", cyc, int'(msg_ready), int'(er));
    chk("msg_done",  cyc, int'(msg_done),  int'(edn));
  endtask

  initial begin
    rst = 1'b1; bg_code = 4'd6; msg_code = 4'd0; msg_blink = 1'b0;
    msg_req = 1'b0; flush = 1'b0;

    // Basic message, 8 held for 12 cycles.
    add(1, 6, 0, 0, 0, 13, 0, 1, 0);
    add(1, 6, 0, 0, 0,  6, 0, 1, 0);
    add(1, 6, 8, 0, 1,  6, 0, 1, 0);
    add(11, 6, 0, 0, 0, 8, 1, 1, 0);
    add(1, 6, 0, 0, 0,  8, 1, 1, 1);
    add(1, 6, 0, 0, 0,  6, 0, 1, 0);
    // 9 then pending 11, no gap.
    add(1, 6, 9, 0, 1,  6, 0, 1, 0);
    add(3, 6, 0, 0, 0,  9, 1, 1, 0);
    add(1, 6, 11, 0, 1, 9, 1, 1, 0);
    add(7, 6, 0, 0, 0,  9, 1, 0, 0);
    add(1, 6, 0, 0, 0,  9, 1, 0, 1);
    add(11, 6, 0, 0, 0, 11, 1, 1, 0);
    add(1, 6, 0, 0, 0, 11, 1, 1, 1);
    add(1, 6, 0, 0, 0,  6, 0, 1, 0);
    // Blinking 10.
    add(1, 6, 10, 1, 1, 6, 0, 1, 0);
    add(4, 6, 0, 0, 0, 10, 1, 1, 0);
    add(4, 6, 0, 0, 0, 13, 1, 1, 0);
    add(3, 6, 0, 0, 0, 10, 1, 1, 0);
    add(1, 6, 0, 0, 0, 10, 1, 1, 1);
    add(1, 6, 0, 0, 0,  6, 0, 1, 0);
    // Bypass at expiry, background change ignored during SHOW.
    add(1, 6, 8, 0, 1,  6, 0, 1, 0);
    add(11, 6, 0, 0, 0, 8, 1, 1, 0);
    add(1, 6, 9, 0, 1,  8, 1, 1, 1);
    add(1, 6, 0, 0, 0,  9, 1, 1, 0);
    add(10, 4, 0, 0, 0, 9, 1, 1, 0);
    add(1, 4, 0, 0, 0,  9, 1, 1, 1);
    add(1, 4, 0, 0, 0,  4, 0, 1, 0);
    // Code 15 sanitised for background and message.
    add(1, 15, 0, 0, 0,  4, 0, 1, 0);
    add(1, 15, 15, 0, 1, 13, 0, 1, 0);
    add(11, 15, 0, 0, 0, 13, 1, 1, 0);
    add(1, 15, 0, 0, 0, 13, 1, 1, 1);
    add(1, 6, 0, 0, 0,  13, 0, 1, 0);
    add(1, 6, 0, 0, 0,   6, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp", -1, int'(disp_code), 13);
    chk("rst_busy", -1, int'(busy), 0);
    chk("rst_done", -1, int'(msg_done), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i].bg, vecs[i].code, vecs[i].blink, vecs[i].req, 1'b0,
           vecs[i].e_disp, vecs[i].e_busy, vecs[i].e_ready, vecs[i].e_done);
    end

    // Flush with pending valid and a request held high.
    step(200, 6, 8, 0, 1, 0,  6, 0, 1, 0);
    step(201, 6, 0, 0, 0, 0,  8, 1, 1, 0);
    step(202, 6, 9, 0, 1, 0,  8, 1, 1, 0);
    step(203, 6, 11, 0, 1, 0, 8, 1, 0, 0);
    step(204, 6, 11, 0, 1, 1, 8, 1, 0, 0);
    step(205, 6, 11, 0, 1, 0, 6, 0, 1, 0);
    step(206, 6, 0, 0, 0, 0, 11, 1, 1, 0);
    step(207, 6, 0, 0, 0, 0, 11, 1, 1, 0);

    // Asynchronous reset mid-hold.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_disp", 208, int'(disp_code), 13);
    chk("arst_busy", 208, int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(209, 6, 0, 0, 0, 0, 13, 0, 1, 0);
    step(210, 6, 0, 0, 0, 0,  6, 0, 1, 0);
    step(211, 6, 0, 0, 0, 0,  6, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
